// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR way selector: per-width Galois taps and the request FSM states.
package lfsr_pkg;

  localparam logic [31:0] Taps8  = 32'h0000_00B8;
  localparam logic [31:0] Taps16 = 32'h0000_B400;
  localparam logic [31:0] Taps32 = 32'h8020_0003;

  typedef enum logic {StIdle, StSearch} state_e;

  // Maximal-length right-shift Galois taps; unsupported widths yield 0.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    taps = '0;
    if (width == 8) taps = Taps8;
    else if (width == 16) taps = Taps16;
    else if (width == 32) taps = Taps32;
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Right-shift Galois LFSR register with seed load; a zero load is replaced by SEED so the
// register can never enter the all-zero lock-up state.
module lfsr_core #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (en_i) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lfsr_way_sel.sv
// Pseudo-random victim way selector: LFSR picks a start way, the FSM then walks round-robin
// past locked ways and reports a one-hot/binary victim with a one-cycle valid strobe.
module lfsr_way_sel
  import lfsr_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH = 16,
  parameter logic [31:0] SEED       = 32'h0000_ACE1,
  parameter int unsigned NUM_WAYS   = 8,
  localparam int unsigned WAY_BITS  = $clog2(NUM_WAYS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  seed_valid_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic [NUM_WAYS-1:0]   lock_mask_i,
  output logic                  valid_o,
  output logic [NUM_WAYS-1:0]   way_oh_o,
  output logic [WAY_BITS-1:0]   way_bin_o,
  output logic                  all_locked_o,
  output logic [LFSR_WIDTH-1:0] lfsr_o
);

  localparam logic [31:0]           TapsFull = lfsr_taps(LFSR_WIDTH);
  localparam logic [LFSR_WIDTH-1:0] Taps     = TapsFull[LFSR_WIDTH-1:0];
  localparam logic [LFSR_WIDTH-1:0] SeedW    = SEED[LFSR_WIDTH-1:0];

  state_e                state_d, state_q;
  logic [WAY_BITS-1:0]   cand_d, cand_q;
  logic [NUM_WAYS-1:0]   mask_d, mask_q;
  logic                  valid_d, valid_q;
  logic                  all_locked_d, all_locked_q;
  logic [NUM_WAYS-1:0]   way_oh_d, way_oh_q;
  logic [WAY_BITS-1:0]   way_bin_d, way_bin_q;
  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic                  lfsr_adv;

  assign ready_o = (state_q == StIdle);
  // Each accepted request also steps the LFSR so consecutive refills see fresh start ways.
  assign lfsr_adv = en_i | (req_i & ready_o);

  lfsr_core #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (Taps),
    .SEED  (SeedW)
  ) u_lfsr_core (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (lfsr_adv),
    .load_i     (seed_valid_i),
    .load_val_i (seed_i),
    .q_o        (lfsr_q)
  );

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    mask_d       = mask_q;
    valid_d      = 1'b0;
    all_locked_d = 1'b0;
    way_oh_d     = way_oh_q;
    way_bin_d    = way_bin_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          cand_d  = lfsr_q[WAY_BITS-1:0];
          mask_d  = lock_mask_i;
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (&mask_q) begin
          valid_d      = 1'b1;
          all_locked_d = 1'b1;
          way_oh_d     = '0;
          way_bin_d    = '0;
          state_d      = StIdle;
        end else if (!mask_q[cand_q]) begin
          valid_d          = 1'b1;
          way_bin_d        = cand_q;
          way_oh_d         = '0;
          way_oh_d[cand_q] = 1'b1;
          state_d          = StIdle;
        end else begin
          // NUM_WAYS is a power of two, so the natural overflow is the modulo wrap.
          cand_d = cand_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cand_q       <= '0;
      mask_q       <= '0;
      valid_q      <= 1'b0;
      all_locked_q <= 1'b0;
      way_oh_q     <= '0;
      way_bin_q    <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      all_locked_q <= all_locked_d;
      way_oh_q     <= way_oh_d;
      way_bin_q    <= way_bin_d;
    end
  end

  assign valid_o      = valid_q;
  assign all_locked_o = all_locked_q;
  assign way_oh_o     = way_oh_q;
  assign way_bin_o    = way_bin_q;
  assign lfsr_o       = lfsr_q;

endmodule

// File: tb/tb_lfsr_way_sel.sv
// Bench for lfsr_way_sel: directed cases plus randomized traffic against a transaction-level
// model (victim found by scanning the mask from the start way), on 8-bit and 16-bit LFSRs.
module tb_lfsr_way_sel;

  localparam logic [7:0] S8 = 8'hAC;
  localparam int unsigned NW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, seed_valid, req;
  logic [7:0] seed, lock_mask;
  logic       ready, valid, all_locked;
  logic [7:0] way_oh, lfsr;
  logic [2:0] way_bin;

  logic        en16;
  logic        ready16, valid16, all_locked16;
  logic [7:0]  way_oh16;
  logic [2:0]  way_bin16;
  logic [15:0] lfsr16;

  lfsr_way_sel #(
    .LFSR_WIDTH (8),
    .SEED       (32'h0000_00AC),
    .NUM_WAYS   (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .req_i        (req),
    .ready_o      (ready),
    .lock_mask_i  (lock_mask),
    .valid_o      (valid),
    .way_oh_o     (way_oh),
    .way_bin_o    (way_bin),
    .all_locked_o (all_locked),
    .lfsr_o       (lfsr)
  );

  lfsr_way_sel #(
    .LFSR_WIDTH (16),
    .SEED       (32'h0000_ACE1),
    .NUM_WAYS   (8)
  ) dut16 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en16),
    .seed_valid_i (1'b0),
    .seed_i       (16'h0000),
    .req_i        (1'b0),
    .ready_o      (ready16),
    .lock_mask_i  (8'h00),
    .valid_o      (valid16),
    .way_oh_o     (way_oh16),
    .way_bin_o    (way_bin16),
    .all_locked_o (all_locked16),
    .lfsr_o       (lfsr16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state.
  logic [7:0] m_lfsr;
  bit         m_busy;
  int         m_cnt;
  bit         m_valid, m_all;
  logic [7:0] m_oh;
  logic [2:0] m_bin;
  bit         p_all;
  logic [7:0] p_oh;
  logic [2:0] p_bin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt8(input logic [7:0] q);
    return q[0] ? ((q >> 1) ^ 8'hB8) : (q >> 1);
  endfunction

  function automatic logic [15:0] nxt16(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = S8; m_busy = 0; m_cnt = 0; m_valid = 0; m_all = 0; m_oh = '0; m_bin = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit         was_busy;
    logic [7:0] cur;
    int         start, w;
    bit         found;
    was_busy = m_busy;
    cur      = m_lfsr;
    m_valid  = 0;
    m_all    = 0;
    if (was_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1; m_all = p_all; m_oh = p_oh; m_bin = p_bin; m_busy = 0;
      end
    end else if (req) begin
      start = int'(cur) % NW;
      found = 0;
      p_all = 1; p_oh = '0; p_bin = '0; m_cnt = 1;
      for (int k = 0; k < NW; k++) begin
        w = (start + k) % NW;
        if (!found && !lock_mask[w]) begin
          found = 1; p_all = 0; p_bin = w[2:0]; p_oh = 8'(1) << w; m_cnt = k + 1;
        end
      end
      m_busy = 1;
    end
    if (seed_valid) m_lfsr = (seed == 8'h00) ? S8 : seed;
    else if (en || (!was_busy && req)) m_lfsr = nxt8(cur);
  endtask

  task automatic compare();
    check("ready", 32'(ready), 32'(!m_busy));
    check("valid", 32'(valid), 32'(m_valid));
    check("all_locked", 32'(all_locked), 32'(m_all));
    check("way_oh", 32'(way_oh), 32'(m_oh));
    check("way_bin", 32'(way_bin), 32'(m_bin));
    check("lfsr", 32'(lfsr), 32'(m_lfsr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    en = 0; seed_valid = 0; seed = '0; req = 0; lock_mask = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    model_reset();
    #1;
    check("rst_lfsr", 32'(lfsr), 32'h00AC);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    compare();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Accept a request and count cycles until the strobe; 0 means it never came.
  task automatic request(input logic [7:0] mask, output int lat);
    req = 1; lock_mask = mask;
    step();
    req = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (lat == 0 && valid) lat = i;
    end
  endtask

  initial begin
    int   lat, cnt;
    bit   zero_seen, done;
    logic [7:0] first;
    rst_n = 1; en16 = 0;
    clear_inputs();
    do_reset();

    // Sequence: AC, 56, 2B, AD, then full period back to AC.
    en = 1;
    step(); check("seq1", 32'(lfsr), 32'h56);
    step(); check("seq2", 32'(lfsr), 32'h2B);
    step(); check("seq3", 32'(lfsr), 32'hAD);
    cnt = 3; zero_seen = 0; done = 0;
    for (int i = 0; i < 300; i++) begin
      if (!done) begin
        step(); cnt++;
        if (lfsr == 8'h00) zero_seen = 1;
        if (lfsr == S8) done = 1;
      end
    end
    check("period8", 32'(cnt), 32'd255);
    check("nonzero8", 32'(zero_seen), 32'd0);

    // Hold, then free way.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("hold", 32'(lfsr), 32'hAC);
    req = 1; lock_mask = 8'h00;
    step(); req = 0;
    check("acc_lfsr", 32'(lfsr), 32'h56);
    step();
    check("free_valid", 32'(valid), 32'd1);
    check("free_bin", 32'(way_bin), 32'd4);
    check("free_oh", 32'(way_oh), 32'h10);
    step();
    check("valid_pulse", 32'(valid), 32'd0);
    check("bin_hold", 32'(way_bin), 32'd4);

    // Skip locked ways, including wrap.
    do_reset();
    request(8'h30, lat);
    check("skip_lat", 32'(lat), 32'd3);
    check("skip_bin", 32'(way_bin), 32'd6);
    do_reset();
    request(8'hF0, lat);
    check("wrap_lat", 32'(lat), 32'd5);
    check("wrap_bin", 32'(way_bin), 32'd0);
    check("wrap_oh", 32'(way_oh), 32'h01);

    // All locked.
    do_reset();
    req = 1; lock_mask = 8'hFF;
    step(); req = 0;
    step();
    check("lock_valid", 32'(valid), 32'd1);
    check("lock_all", 32'(all_locked), 32'd1);
    check("lock_oh", 32'(way_oh), 32'h00);

    // Seed loads and busy requests.
    en = 1; step(); step(); en = 0;
    seed_valid = 1; seed = 8'h00; step();
    check("seed0", 32'(lfsr), 32'hAC);
    seed = 8'h01; en = 1; step();
    check("seed_wins", 32'(lfsr), 32'h01);
    seed_valid = 0; en = 0;
    req = 1; lock_mask = 8'hF0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) seed_valid = 1;
      if (i == 4) seed_valid = 0;
      if (i == 2) lock_mask = 8'h00;
      step();
    end
    req = 0;
    for (int i = 0; i < 8; i++) step();

    // Abort mid-search.
    do_reset();
    req = 1; lock_mask = 8'hF0; step(); req = 0; step();
    check("busy", 32'(ready), 32'd0);
    rst_n = 0;
    model_reset();
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_lfsr", 32'(lfsr), 32'hAC);
    compare();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      en         = ($urandom_range(0, 3) == 0);
      seed_valid = ($urandom_range(0, 15) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req        = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: lock_mask = 8'h00;
        1: lock_mask = 8'hFF;
        2: lock_mask = ~(8'(1) << $urandom_range(0, 7));
        default: lock_mask = 8'($urandom);
      endcase
      step();
    end
    clear_inputs();

    // 16-bit period.
    do_reset();
    check("rst16", 32'(lfsr16), 32'hACE1);
    first = 8'h00;
    en16 = 1;
    @(posedge clk); @(negedge clk);
    check("seq16", 32'(lfsr16), 32'hE270);
    check("model16", 32'(lfsr16), 32'(nxt16(16'hACE1)));
    cnt = 1; zero_seen = 0; done = 0;
    for (int i = 0; i < 66000; i++) begin
      if (!done) begin
        @(posedge clk); @(negedge clk); cnt++;
        if (lfsr16 == 16'h0000) zero_seen = 1;
        if (lfsr16 == 16'hACE1) done = 1;
      end
    end
    en16 = 0;
    check("period16", 32'(cnt), 32'd65535);
    check("nonzero16", 32'(zero_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
